game_ctrl_multilevel: RTL and testbench
=======================================

Name: game_ctrl_multilevel

Overview:
- Parametrised successor to the top-level game sequencer. It runs authentication with retry lockout, then an N-level bomb-defusal game with per-level timer reload, then the success or game-over sequences.
- Sits between the authentication module, the sequence verifier, the countdown timer and the display/LED drivers.
- `state_code` is the single status word the display logic decodes.

Parameters:
- NUM_LEVELS, 3, number of levels to pass for game success (legal range 1..16).
- MAX_AUTH_TRIES, 3, consecutive failed credential attempts that trigger lockout (1..15).
- LOCKOUT_CYCLES, 16, clk cycles spent in lockout (≥1).
- TIME_W, 8, width of the `cur_time` countdown value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- auth_valid  in  1  one-cycle strobe: a credential check has completed
- auth_ok  in  1  qualifies `auth_valid`: 1 = correct credentials
- level_done  in  1  one-cycle strobe from the sequence verifier: current level finished
- level_pass  in  1  qualifies `level_done`: 1 = pass, 0 = fail
- cur_time  in  TIME_W  remaining time from the countdown timer
- seq_done  in  1  one-cycle strobe from the display: current animation finished
- state_code  out  7  registered status code
- level  out  4  current level index, 0-based
- level_start  out  1  one-cycle pulse: a level begins (enables the verifier)
- timer_load  out  1  one-cycle pulse: the timer reloads its start value
- locked  out  1  high while in LOCKOUT

Behaviour:
- Reset (clk edge with rst=0):
  - state=AUTH; state_code=0x00; level=0; fail_cnt=0; lock_cnt=0; level_start=0; timer_load=0; locked=0.
  - Reset has priority over every input, including mid-level or mid-lockout.
- All outputs are registered. A code reflects the state entered at that edge.
- AUTH:
  - `auth_valid & auth_ok`: fail_cnt←0, level←0, go to LEVEL_START.
  - `auth_valid & !auth_ok`: fail_cnt++, state_code=0x02.
    - If the incremented fail_cnt equals MAX_AUTH_TRIES: go to LOCKOUT, lock_cnt←LOCKOUT_CYCLES-1, state_code=0x03, locked=1.
  - No `auth_valid`: hold. state_code stays 0x00, or 0x02 after a failure, until the next attempt.
- LOCKOUT:
  - `auth_valid` is ignored.
  - lock_cnt decrements each cycle.
  - On the cycle lock_cnt==0: go to AUTH, fail_cnt←0, state_code=0x00, locked=0.
  - Lockout therefore lasts exactly LOCKOUT_CYCLES cycles with locked=1.
- LEVEL_START (exactly 1 cycle):
  - level_start=1, timer_load=1, state_code=0x0F.
  - Next: IN_LEVEL.
  - Contract: the timer reloads on this edge, so `cur_time` is valid when IN_LEVEL is first evaluated.
- IN_LEVEL (state_code = 0x10 | level), priority order:
  1. cur_time==0 → GAME_OVER. Timeout wins over a simultaneous level_done.
  2. level_done & !level_pass → GAME_OVER.
  3. level_done & level_pass → LEVEL_PASS, state_code = 0x40 | level.
  4. Otherwise hold.
- LEVEL_PASS:
  - Waits for seq_done.
  - If level==NUM_LEVELS-1: go to GAME_SUCCESS.
  - Else: level++, go to LEVEL_START.
- GAME_SUCCESS (state_code=0x20) and GAME_OVER (state_code=0x30):
  - Hold until seq_done.
  - Then enter END for 1 cycle with state_code=0x21 or 0x31 respectively.
  - Then AUTH, state_code=0x00, level=0, fail_cnt=0.
- level_done and seq_done strobes arriving in any state other than the ones above are ignored. No queuing.
- level_start and timer_load are high only in LEVEL_START, and 0 in all other cycles.
- level never exceeds NUM_LEVELS-1. No wrap-around.

Test Plan:
- Clean run (NUM_LEVELS=3):
  - Stimulus: auth ok, then level pass + seq_done on each level.
  - Required codes: 0x0F, 0x10, 0x40, 0x0F, 0x11, 0x41, 0x0F, 0x12, 0x42, 0x20, 0x21, 0x00.
  - level_start pulses exactly 3 times.
- Lockout:
  - Stimulus: 3 failed auth_valid strobes.
  - Required: codes 0x02, 0x02, 0x03; locked=1 for exactly 16 cycles; auth_ok strobe during lockout ignored; returns to 0x00 with fail_cnt=0.
- Retry reset:
  - Stimulus: 2 failures, then success; later return to AUTH and 2 more failures.
  - Required: no lockout, because the success cleared fail_cnt.
- Timeout priority:
  - Stimulus: in level 1, cur_time=0 on the same cycle as level_done & level_pass.
  - Required: GAME_OVER, codes 0x30, then 0x31 after seq_done, then 0x00.
- Level fail:
  - Stimulus: level_done & !level_pass in level 0.
  - Required: 0x30, no level increment, timer_load stays 0.
- Mid-game reset:
  - Stimulus: rst=0 for one edge while in IN_LEVEL level 2.
  - Required: next cycle state_code=0x00, level=0, all pulses 0, locked=0.

Source files
------------

// File: rtl/game_ctrl_multilevel.sv
// Top-level game sequencer: authentication with retry lockout, then an N-level
// bomb-defusal game with per-level timer reload, then success/game-over sequences.
module game_ctrl_multilevel #(
  parameter int NUM_LEVELS     = 3,
  parameter int MAX_AUTH_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIME_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auth_valid,
  input  logic              auth_ok,
  input  logic              level_done,
  input  logic              level_pass,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              seq_done,
  output logic [6:0]        state_code,
  output logic [3:0]        level,
  output logic              level_start,
  output logic              timer_load,
  output logic              locked
);

  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  // Strobe handshake: every *_valid / *_done input is a one-cycle strobe sampled
  // on the rising clk edge; there is no ready/backpressure and no queuing.
  typedef enum logic [2:0] {
    S_AUTH, S_LOCKOUT, S_LEVEL_START, S_IN_LEVEL,
    S_LEVEL_PASS, S_GAME_SUCCESS, S_GAME_OVER, S_END
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          code_q, code_d;
  logic [3:0]          level_q, level_d;
  logic [3:0]          fail_q, fail_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic                ls_q, ls_d;
  logic                locked_q, locked_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_AUTH;
      code_q   <= 7'h00;
      level_q  <= 4'd0;
      fail_q   <= 4'd0;
      lock_q   <= '0;
      ls_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      level_q  <= level_d;
      fail_q   <= fail_d;
      lock_q   <= lock_d;
      ls_q     <= ls_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    level_d  = level_q;
    fail_d   = fail_q;
    lock_d   = lock_q;
    ls_d     = 1'b0;
    locked_d = locked_q;
    unique case (state_q)
      S_AUTH: begin
        if (auth_valid && auth_ok) begin
          fail_d  = 4'd0;
          level_d = 4'd0;
          ls_d    = 1'b1;
          code_d  = 7'h0F;
          state_d = S_LEVEL_START;
        end else if (auth_valid) begin
          fail_d = fail_q + 4'd1;
          code_d = 7'h02;
          if (fail_d == 4'(MAX_AUTH_TRIES)) begin
            state_d  = S_LOCKOUT;
            lock_d   = LOCK_W'(LOCKOUT_CYCLES - 1);
            code_d   = 7'h03;
            locked_d = 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        // Final cycle of lockout is the one where the counter has reached zero.
        if (lock_q == '0) begin
          state_d  = S_AUTH;
          fail_d   = 4'd0;
          code_d   = 7'h00;
          locked_d = 1'b0;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      S_LEVEL_START: begin
        state_d = S_IN_LEVEL;
        code_d  = {3'b001, level_q};
      end
      S_IN_LEVEL: begin
        if (cur_time == '0 || (level_done && !level_pass)) begin
          state_d = S_GAME_OVER;
          code_d  = 7'h30;
        end else if (level_done) begin
          state_d = S_LEVEL_PASS;
          code_d  = {3'b100, level_q};
        end
      end
      S_LEVEL_PASS: begin
        if (seq_done) begin
          if (level_q == 4'(NUM_LEVELS - 1)) begin
            state_d = S_GAME_SUCCESS;
            code_d  = 7'h20;
          end else begin
            level_d = level_q + 4'd1;
            ls_d    = 1'b1;
            code_d  = 7'h0F;
            state_d = S_LEVEL_START;
          end
        end
      end
      S_GAME_SUCCESS: begin
        if (seq_done) begin
          state_d = S_END;
          code_d  = 7'h21;
        end
      end
      S_GAME_OVER: begin
        if (seq_done) begin
          state_d = S_END;
          code_d  = 7'h31;
        end
      end
      S_END: begin
        state_d = S_AUTH;
        code_d  = 7'h00;
        level_d = 4'd0;
        fail_d  = 4'd0;
      end
      default: begin
        state_d = S_AUTH;
        code_d  = 7'h00;
      end
    endcase
  end

  assign state_code  = code_q;
  assign level       = level_q;
  assign level_start = ls_q;
  assign timer_load  = ls_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_game_ctrl_multilevel.sv
// Directed bench for game_ctrl_multilevel: auth, lockout, clean run, level fail,
// timeout priority and mid-game reset, with hand-computed status codes.
module tb_game_ctrl_multilevel;

  logic       clk = 1'b0;
  logic       rst;
  logic       auth_valid, auth_ok, level_done, level_pass, seq_done;
  logic [7:0] cur_time;
  logic [6:0] state_code;
  logic [3:0] level;
  logic       level_start, timer_load, locked;

  int checks   = 0;
  int failures = 0;
  int ls_cnt   = 0;

  always #5 clk = ~clk;

  game_ctrl_multilevel #(
    .NUM_LEVELS(3), .MAX_AUTH_TRIES(3), .LOCKOUT_CYCLES(16), .TIME_W(8)
  ) dut (
    .clk(clk), .rst(rst), .auth_valid(auth_valid), .auth_ok(auth_ok),
    .level_done(level_done), .level_pass(level_pass), .cur_time(cur_time),
    .seq_done(seq_done), .state_code(state_code), .level(level),
    .level_start(level_start), .timer_load(timer_load), .locked(locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (level_start) ls_cnt++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_code(input string tag, input logic [6:0] exp);
    chk(tag, {1'b0, state_code}, {1'b0, exp});
  endtask

  task automatic auth(input logic ok);
    auth_valid = 1'b1; auth_ok = ok;
    tick();
    auth_valid = 1'b0; auth_ok = 1'b0;
  endtask

  task automatic lvl(input logic pass);
    level_done = 1'b1; level_pass = pass;
    tick();
    level_done = 1'b0; level_pass = 1'b0;
  endtask

  task automatic seq();
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
  endtask

  initial begin
    int lk;
    int ls_base;
    rst = 1'b0; auth_valid = 1'b0; auth_ok = 1'b0; level_done = 1'b0;
    level_pass = 1'b0; seq_done = 1'b0; cur_time = 8'd50;

    // Reset state
    tick(); tick();
    chk_code("rst_code", 7'h00);
    chk("rst_level", {4'd0, level}, 8'd0);
    chk("rst_pulses", {6'd0, level_start, timer_load}, 8'd0);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    rst = 1'b1;
    tick();
    seq(); lvl(1'b1);
    chk_code("auth_ignores_strobes", 7'h00);

    // Clean run through three levels
    ls_base = ls_cnt;
    auth(1'b1);
    chk_code("clean_ls0", 7'h0F);
    chk("clean_pulses0", {6'd0, level_start, timer_load}, 8'h03);
    tick(); chk_code("clean_in0", 7'h10);
    chk("clean_pulses_off", {6'd0, level_start, timer_load}, 8'h00);
    tick(); tick(); chk_code("clean_hold0", 7'h10);
    lvl(1'b1); chk_code("clean_pass0", 7'h40);
    tick(); chk_code("clean_wait_seq", 7'h40);
    seq(); chk_code("clean_ls1", 7'h0F);
    chk("clean_level1", {4'd0, level}, 8'd1);
    tick(); chk_code("clean_in1", 7'h11);
    lvl(1'b1); chk_code("clean_pass1", 7'h41);
    seq(); chk_code("clean_ls2", 7'h0F);
    tick(); chk_code("clean_in2", 7'h12);
    lvl(1'b1); chk_code("clean_pass2", 7'h42);
    seq(); chk_code("clean_success", 7'h20);
    chk("clean_level_cap", {4'd0, level}, 8'd2);
    seq(); chk_code("clean_end", 7'h21);
    tick(); chk_code("clean_auth", 7'h00);
    chk("clean_level_rst", {4'd0, level}, 8'd0);
    chk("clean_ls_count", 8'(ls_cnt - ls_base), 8'd3);

    // Lockout after three failures
    auth(1'b0); chk_code("lock_f1", 7'h02);
    tick();     chk_code("lock_f1_hold", 7'h02);
    auth(1'b0); chk_code("lock_f2", 7'h02);
    chk("lock_f2_unlocked", {7'd0, locked}, 8'd0);
    auth(1'b0); chk_code("lock_f3", 7'h03);
    lk = 1;
    auth_valid = 1'b1; auth_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      auth_valid = 1'b0; auth_ok = 1'b0;
      if (!locked) break;
      lk++;
    end
    chk("lock_cycles", 8'(lk), 8'd16);
    chk_code("lock_exit", 7'h00);

    // fail_cnt cleared by lockout, then by a successful auth
    auth(1'b0); auth(1'b0);
    chk("retry_no_lock_a", {7'd0, locked}, 8'd0);
    auth(1'b1); chk_code("retry_ok", 7'h0F);
    tick(); chk_code("fail_in0", 7'h10);
    lvl(1'b0); chk_code("fail_over", 7'h30);
    chk("fail_level", {4'd0, level}, 8'd0);
    chk("fail_timer_load", {7'd0, timer_load}, 8'd0);
    seq(); chk_code("fail_end", 7'h31);
    tick(); chk_code("fail_auth", 7'h00);
    auth(1'b0); auth(1'b0);
    chk_code("retry_two_more", 7'h02);
    chk("retry_no_lock_b", {7'd0, locked}, 8'd0);

    // Timeout wins over a simultaneous pass in level 1
    auth(1'b1); tick();
    lvl(1'b1); seq(); tick();
    chk_code("to_in1", 7'h11);
    cur_time = 8'd0;
    lvl(1'b1);
    cur_time = 8'd50;
    chk_code("to_over", 7'h30);
    chk("to_level", {4'd0, level}, 8'd1);
    seq(); chk_code("to_end", 7'h31);
    tick(); chk_code("to_auth", 7'h00);
    chk("to_level_rst", {4'd0, level}, 8'd0);

    // Reset in the middle of level 2
    auth(1'b1); tick();
    lvl(1'b1); seq(); tick();
    lvl(1'b1); seq(); tick();
    chk_code("mid_in2", 7'h12);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_code("mid_rst_code", 7'h00);
    chk("mid_rst_level", {4'd0, level}, 8'd0);
    chk("mid_rst_pulses", {6'd0, level_start, timer_load}, 8'd0);
    chk("mid_rst_locked", {7'd0, locked}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
